// File: rtl/async_fifo_pkg.sv
// async_fifo_pkg
//   Shared constants for the async_fifo block: default word width, default
//   address width, and the pointer-width helper (address width plus one wrap
//   bit). Imported by async_fifo and async_fifo_mem.
package async_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_PTR_WIDTH  = DEF_ADDR_WIDTH + 1;

  // Pointers carry one extra MSB so full and empty can be told apart when
  // the low address bits match.
  function automatic int ptr_width(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/async_fifo_mem.sv
// async_fifo_mem
//   Simple dual-port RAM: one write port, one synchronous read port with a
//   registered output. The array itself is never reset; only the read
//   register clears on rst.
// Ports:
//   clk, rst         clock, async active-high reset (read register only)
//   we, waddr, wdata write port
//   re, raddr        read request/address; rdata updates on the next edge
//   rdata            registered read word, holds when re is low
module async_fifo_mem
  import async_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // The controller never reads and writes the same slot on one edge:
  // a write targets wr_ptr, a read targets rd_ptr, and they only alias
  // when empty (no read) or full (no write).
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/async_fifo.sv
// async_fifo
//   Single-clock FIFO, 2^ADDR_WIDTH words of DATA_WIDTH bits, with a
//   registered read port and full/almost_full/empty/almost_empty status.
//   Strict first-in-first-out order across pointer wrap.
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   wr_data, wr_en            write word / request (dropped while full)
//   full, almost_full         occupancy == DEPTH / >= DEPTH - AF_MARGIN
//   rd_en                     read request (dropped while empty)
//   rd_data, rd_valid         registered word, valid the cycle after rd_en
//   empty, almost_empty       occupancy == 0 / <= AE_MARGIN
//   overflow, underflow       sticky error flags, present only when
//                             ASYNC_FIFO_ERR_FLAGS_EN is defined
module async_fifo
  import async_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_MARGIN  = 1,
  parameter int AE_MARGIN  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PTR_W = ptr_width(ADDR_WIDTH);
  localparam logic [PTR_W-1:0] AF_THR = PTR_W'(DEPTH - AF_MARGIN);
  localparam logic [PTR_W-1:0] AE_THR = PTR_W'(AE_MARGIN);

  logic [PTR_W-1:0] wr_ptr, rd_ptr, occ;
  logic             wr_acc, rd_acc;

  // Flags decode from the registered pointers only, so they move one
  // cycle after an accepted transfer.
  assign occ          = wr_ptr - rd_ptr;
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                        (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]);
  assign almost_full  = (occ >= AF_THR);
  assign almost_empty = (occ <= AE_THR);

  // Both requests qualify against the pre-edge flags: at empty only the
  // write lands, at full only the read lands.
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      rd_valid <= rd_acc;
    end
  end

`ifdef ASYNC_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end
`endif

  async_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata (wr_data),
    .re    (rd_acc),
    .raddr (rd_ptr[ADDR_WIDTH-1:0]),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_async_fifo.sv
// tb_async_fifo
//   Directed plus randomized stimulus for async_fifo, checked every cycle
//   against a queue-based reference model of occupancy and data order.
module tb_async_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 32;
  localparam int AF_M  = 1;
  localparam int AE_M  = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] wr_data = '0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic          full, almost_full, empty, almost_empty, rd_valid;
  logic [DW-1:0] rd_data;
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
  logic          overflow, underflow;
  logic          m_ovf = 1'b0, m_udf = 1'b0;
`endif

  async_fifo #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (5),
    .AF_MARGIN  (AF_M),
    .AE_MARGIN  (AE_M)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .full         (full),
    .almost_full  (almost_full),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .empty        (empty),
    .almost_empty (almost_empty)
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    ,
    .overflow     (overflow),
    .underflow    (underflow)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a queue of stored words plus the last popped word.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_last = '0;
  logic          m_vld  = 1'b0;
  int            n_cmp  = 0;
  int            n_err  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("empty",        32'(empty),        32'(n == 0));
    chk("full",         32'(full),         32'(n == DEPTH));
    chk("almost_empty", 32'(almost_empty), 32'(n <= AE_M));
    chk("almost_full",  32'(almost_full),  32'(n >= DEPTH - AF_M));
    chk("rd_valid",     32'(rd_valid),     32'(m_vld));
    chk("rd_data",      32'(rd_data),      32'(m_last));
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    chk("overflow",     32'(overflow),     32'(m_ovf));
    chk("underflow",    32'(underflow),    32'(m_udf));
`endif
  endtask

  task automatic model_reset();
    q.delete();
    m_last = '0;
    m_vld  = 1'b0;
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    m_ovf = 1'b0;
    m_udf = 1'b0;
`endif
  endtask

  // One clock: drive, edge, update model from pre-edge occupancy, check.
  task automatic step(input logic we, input logic [DW-1:0] wd, input logic re);
    int pre;
    wr_en = we; wr_data = wd; rd_en = re;
    pre = q.size();
    @(posedge clk); #1;
    m_vld = re && (pre > 0);
    if (m_vld) m_last = q.pop_front();
    if (we && pre < DEPTH) q.push_back(wd);
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    if (we && pre == DEPTH) m_ovf = 1'b1;
    if (re && pre == 0)     m_udf = 1'b1;
`endif
    wr_en = 1'b0; rd_en = 1'b0;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();

    // Fill 0..31, then a dropped write of 99
    for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(i), 1'b0);
    step(1'b1, 16'd99, 1'b0);
    chk("occ_after_drop", 32'(full), 32'd1);

    // Drain 32 in order, then an extra read on empty
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, '0, 1'b1);
      chk("drain_order", 32'(rd_data), 32'(i));
    end
    step(1'b0, '0, 1'b1);

    // Wrap stress: 40 writes with reads gated by model non-empty
    for (int i = 0; i < 40; i++) step(1'b1, DW'(i), q.size() > 0);
    while (q.size() > 0) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // Simultaneous access at occupancy 10
    for (int i = 0; i < 10; i++) step(1'b1, DW'(16'h100 + i), 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, DW'(16'h200 + i), 1'b1);
      chk("simul_order", 32'(rd_data), 32'(16'h100 + i));
    end
    while (q.size() > 0) step(1'b0, '0, 1'b1);

    // Simultaneous at empty: only the write lands
    step(1'b1, 16'hBEEF, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("empty_simul_word", 32'(rd_data), 32'h0000BEEF);

    // Simultaneous at full: only the read lands
    for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(16'h300 + i), 1'b0);
    step(1'b1, 16'hDEAD, 1'b1);
    while (q.size() > 0) step(1'b0, '0, 1'b1);

    // Randomized phases with different write/read bias
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 150; i++) begin
        logic we, re;
        we = ($urandom_range(0, 9) < 2 + 2 * p);
        re = ($urandom_range(0, 9) < 8 - 2 * p);
        step(we, DW'($urandom), re);
      end
    end
    while (q.size() > 0) step(1'b0, '0, 1'b1);

`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    // Overflow / underflow stick until reset
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < DEPTH + 1; i++) step(1'b1, DW'(i), 1'b0);
    repeat (3) step(1'b0, '0, 1'b0);
    do_reset();
`endif

    // Mid-operation reset at occupancy 7: flags return without a clock edge
    for (int i = 0; i < 7; i++) step(1'b1, DW'(16'h400 + i), 1'b0);
    step(1'b0, '0, 1'b1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk); #1;
    rst = 1'b0;
    step(1'b0, '0, 1'b1);
    step(1'b1, 16'h5A5A, 1'b0);
    step(1'b0, '0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
